pll_lock_controller: RTL
========================

// Module: pll_lock_controller
// PURPOSE
//  Start-up and lock sequencer for the PLL phase detector, clocked by the reference clock.
//  Holds the phase detector in reset, then binary-searches the VCO coarse band from the detector's up/down outputs.
//  Then releases the loop and declares lock once up/down activity stays balanced.
//  Sits beside pll_phase_detector. It drives the detector's reset and the VCO band select.
// PARAMETERS
//  BAND_W        5    VCO coarse band select width (band search steps = BAND_W)
//  CNT_W         8    up/down window counter width; WINDOW < 2**CNT_W required
//  WINDOW        128  ref cycles per measurement window
//  RST_CYCLES    16   ref cycles pd_reset_out held high in PD_RESET
//  SETTLE        32   ref cycles waited after each band change before measuring
//  LOCK_TOL      4    max |up_cnt - down_cnt| per window counted as balanced
//  LOCK_WINDOWS  4    consecutive balanced windows needed to assert lock_out
// PORTS
//  ref_clk_in      in   1       reference clock; only clock, all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  en_in           in   1       enable; low forces IDLE
//  recal_in        in   1       one-cycle pulse; in TRACK restarts at PD_RESET
//  up_pulse_in     in   1       phase detector up output (async; synchronised inside)
//  down_pulse_in   in   1       phase detector down output (async; synchronised inside)
//  pd_reset_out    out  1       phase detector reset (1 = held in reset)
//  vco_band_out    out  BAND_W  VCO coarse band; higher code = faster VCO
//  cal_done_out    out  1       band search complete (high in TRACK)
//  lock_out        out  1       loop locked
//  lock_lost_out   out  1       sticky: lock was lost since the last IDLE/reset
// BEHAVIOUR
//  Reset values:
//   - pd_reset_out=1; vco_band_out=0; cal_done_out=0; lock_out=0; lock_lost_out=0
//   - state=IDLE; all counters 0
//  Synchronisers: up/down each pass a 2-flop synchroniser (2-cycle latency); counters see only the synchronised bits (su, sd).
//  Window:
//   - Each window counts exactly WINDOW cycles.
//   - up_cnt += su and down_cnt += sd every cycle; both increment if su and sd are both high.
//   - net = up_cnt - down_cnt (signed, CNT_W+1 bits), evaluated on the last window cycle including that cycle's samples.
//   - Counters clear for the next window.
//  States:
//   - IDLE: pd_reset_out=1; band, outputs and lock_lost_out cleared. en_in=1 -> PD_RESET next cycle.
//   - PD_RESET: pd_reset_out=1 for RST_CYCLES cycles. vco_band_out={1,0...0}, bit index b=BAND_W-1. Then -> SETTLE.
//   - SETTLE: pd_reset_out=0; wait SETTLE cycles, counters held at 0 -> MEASURE.
//   - MEASURE: one window. net>0 keeps bit b, else clears bit b (net==0 clears).
//       - If b>0: set bit b-1, b=b-1, go to SETTLE.
//       - If b==0: go to TRACK.
//       - The band update is visible the cycle after evaluation.
//   - TRACK: cal_done_out=1; pd_reset_out=0; windows run back-to-back.
//       - |net|<=LOCK_TOL increments bal_cnt (saturates at LOCK_WINDOWS).
//       - Otherwise bal_cnt=0.
//       - lock_out=1 the cycle after the evaluation that makes bal_cnt==LOCK_WINDOWS.
//       - While lock_out=1, an evaluation with |net|>LOCK_TOL makes lock_out=0 and lock_lost_out=1 next cycle; stay in TRACK and relock is allowed.
//  Timing: with en_in first sampled high at edge 0, cal_done_out rises at edge 1+RST_CYCLES+BAND_W*(SETTLE+WINDOW) (817 at defaults).
//  Boundaries:
//   - en_in low in any state: IDLE next cycle; pd_reset_out=1 that cycle; band, cal_done_out, lock_out and lock_lost_out cleared.
//   - reset has priority over en_in.
//   - recal_in in TRACK: -> PD_RESET; cal_done_out, lock_out and bal_cnt cleared; lock_lost_out kept.
//   - recal_in in any other state is ignored.
//   - Counters never wrap (WINDOW < 2**CNT_W).
// TESTING
//  1. Hold reset 3 cycles -> pd_reset_out=1, vco_band_out=0, cal_done_out=0, lock_out=0, lock_lost_out=0.
//  2. en_in=1, up_pulse_in=1, down_pulse_in=0 -> band walks 10000,11000..11111.
//     vco_band_out=5'h1F; cal_done_out rises at edge 817.
//  3. en_in=1, down_pulse_in=1, up_pulse_in=0 -> vco_band_out=5'h00 at cal_done_out; lock_out stays 0 thereafter.
//  4. up and down both toggle 1-of-2 cycles in phase -> net=0.
//     vco_band_out=0 at cal_done_out; lock_out=1 at edge 817+4*128+1=1330.
//  5. From test 4 locked, force up=1 and down=0 -> at the next window end lock_out=0, lock_lost_out=1.
//     Restore balance -> lock_out=1 again after 4 windows; lock_lost_out stays 1.
//  6. Drop en_in at edge 300 (mid-search) -> IDLE at edge 301: pd_reset_out=1, vco_band_out=0.
//     Re-raise en_in -> full sequence restarts and timing matches test 2.

Source files
------------

// File: rtl/pll_lock_controller_if.sv
// pll_lock_controller_if: control/status bundle between the PLL lock sequencer and its environment
//  master: drives en/recal/up/down, observes pd_reset/band/cal_done/lock/lock_lost
//  slave : the sequencer side
interface pll_lock_controller_if #(parameter int BAND_W = 5);
  logic en_in;
  logic recal_in;
  logic up_pulse_in;
  logic down_pulse_in;
  logic pd_reset_out;
  logic [BAND_W-1:0] vco_band_out;
  logic cal_done_out;
  logic lock_out;
  logic lock_lost_out;
  modport master (
    output en_in, recal_in, up_pulse_in, down_pulse_in,
    input pd_reset_out, vco_band_out, cal_done_out, lock_out, lock_lost_out
  );
  modport slave (
    input en_in, recal_in, up_pulse_in, down_pulse_in,
    output pd_reset_out, vco_band_out, cal_done_out, lock_out, lock_lost_out
  );
endinterface

// File: rtl/pll_lock_controller.sv
// pll_lock_controller: PD reset, binary search of VCO coarse band, then lock detection from up/down balance
//  ref_clk_in/reset : reference clock, synchronous active-high reset
//  bus.en_in/recal_in/up_pulse_in/down_pulse_in : enable, recalibrate pulse, async PD outputs
//  bus.pd_reset_out/vco_band_out/cal_done_out/lock_out/lock_lost_out : PD reset, band, status
module pll_lock_controller #(
  parameter int BAND_W       = 5,
  parameter int CNT_W        = 8,
  parameter int WINDOW       = 128,
  parameter int RST_CYCLES   = 16,
  parameter int SETTLE       = 32,
  parameter int LOCK_TOL     = 4,
  parameter int LOCK_WINDOWS = 4
) (
  input logic ref_clk_in,
  input logic reset,
  pll_lock_controller_if.slave bus
);
  localparam int TW = $clog2(RST_CYCLES + SETTLE + WINDOW + 1);
  localparam int BW = BAND_W > 1 ? $clog2(BAND_W) : 1;
  localparam int LW = $clog2(LOCK_WINDOWS + 1);
  typedef enum logic [2:0] {S_IDLE, S_PD_RESET, S_SETTLE, S_MEASURE, S_TRACK} state_t;
  state_t state_q, state_d;
  logic [1:0] up_sync_q, up_sync_d, dn_sync_q, dn_sync_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d, up_sum, dn_sum;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] bal_q, bal_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic pd_reset_q, pd_reset_d, cal_done_q, cal_done_d, lock_q, lock_d, lost_q, lost_d;
  logic signed [CNT_W:0] net;
  logic [CNT_W:0] net_abs;
  logic win_end, balanced, counting;
  always_comb begin
    up_sync_d = {up_sync_q[0], bus.up_pulse_in};
    dn_sync_d = {dn_sync_q[0], bus.down_pulse_in};
    up_sum    = up_cnt_q + CNT_W'(up_sync_q[1]);
    dn_sum    = dn_cnt_q + CNT_W'(dn_sync_q[1]);
    net       = $signed({1'b0, up_sum}) - $signed({1'b0, dn_sum});
    net_abs   = net < 0 ? $unsigned(-net) : $unsigned(net);
    balanced  = net_abs <= (CNT_W+1)'(LOCK_TOL);
    win_end   = tmr_q == TW'(WINDOW - 1);
    counting  = state_q == S_MEASURE || state_q == S_TRACK;
  end
  always_ff @(posedge ref_clk_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      up_sync_q  <= '0;
      dn_sync_q  <= '0;
      up_cnt_q   <= '0;
      dn_cnt_q   <= '0;
      tmr_q      <= '0;
      bit_q      <= '0;
      bal_q      <= '0;
      band_q     <= '0;
      pd_reset_q <= 1'b1;
      cal_done_q <= 1'b0;
      lock_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_sync_q  <= up_sync_d;
      dn_sync_q  <= dn_sync_d;
      up_cnt_q   <= up_cnt_d;
      dn_cnt_q   <= dn_cnt_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      bal_q      <= bal_d;
      band_q     <= band_d;
      pd_reset_q <= pd_reset_d;
      cal_done_q <= cal_done_d;
      lock_q     <= lock_d;
      lost_q     <= lost_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_PD_RESET;
      S_PD_RESET: if (tmr_q == TW'(RST_CYCLES)) state_d = S_SETTLE;
      S_SETTLE:   if (tmr_q == TW'(SETTLE - 1)) state_d = S_MEASURE;
      S_MEASURE:  if (win_end) state_d = bit_q == '0 ? S_TRACK : S_SETTLE;
      S_TRACK:    if (bus.recal_in) state_d = S_PD_RESET;
      default:    state_d = S_IDLE;
    endcase
    if (!bus.en_in) state_d = S_IDLE;
    // one timer serves reset hold, settle wait and window length; TRACK restarts it every window
    tmr_d = (state_d != state_q || state_d == S_IDLE || (state_q == S_TRACK && win_end)) ? '0 : tmr_q + 1'b1;
  end
  always_comb begin
    up_cnt_d = (counting && !win_end && state_d == state_q) ? up_sum : '0;
    dn_cnt_d = (counting && !win_end && state_d == state_q) ? dn_sum : '0;
    band_d   = band_q;
    bit_d    = bit_q;
    // net==0 clears the bit under test: ties resolve toward the slower band
    if (state_q == S_MEASURE && win_end) begin
      band_d[bit_q] = !net[CNT_W] && net != 0;
      if (bit_q != '0) begin
        band_d[bit_q - 1'b1] = 1'b1;
        bit_d = bit_q - 1'b1;
      end
    end
    if (state_d == S_PD_RESET) begin
      band_d = {1'b1, {(BAND_W-1){1'b0}}};
      bit_d  = BW'(BAND_W - 1);
    end
    if (state_d == S_IDLE) begin
      band_d = '0;
      bit_d  = '0;
    end
    bal_d = state_d != S_TRACK ? '0 :
            (state_q == S_TRACK && win_end) ? (balanced ? (bal_q == LW'(LOCK_WINDOWS) ? bal_q : bal_q + 1'b1) : '0) :
            bal_q;
    pd_reset_d = state_d == S_IDLE || state_d == S_PD_RESET;
    cal_done_d = state_d == S_TRACK;
    lock_d     = state_d == S_TRACK && state_q == S_TRACK && bal_q == LW'(LOCK_WINDOWS);
    // sticky loss: only a lock dropped while staying in TRACK counts, recal keeps the flag
    lost_d     = state_d != S_IDLE && (lost_q || (lock_q && !lock_d && state_d == S_TRACK));
  end
  assign bus.pd_reset_out  = pd_reset_q;
  assign bus.vco_band_out  = band_q;
  assign bus.cal_done_out  = cal_done_q;
  assign bus.lock_out      = lock_q;
  assign bus.lock_lost_out = lost_q;
endmodule
